// File: rtl/matmul_pkg.sv
// matmul_pkg: sizes, state encoding and bank selects shared by
// the feeder, the 3x3 MAC array and its consumer.
package matmul_pkg;

  localparam int N     = 3;
  localparam int DW    = 4;
  localparam int ACC_W = 10;

  typedef enum logic [1:0] {
    IDLE,
    CLR,
    STREAM,
    DONE
  } state_t;

  localparam logic SEL_W = 1'b0;
  localparam logic SEL_X = 1'b1;

endpackage

// File: rtl/matmul_operand_bank.sv
// matmul_operand_bank: 3x3 operand register file, one write port,
// one column (COL_RD=1) or row (COL_RD=0) read port.
module matmul_operand_bank
  import matmul_pkg::*;
#(
  parameter int DW     = matmul_pkg::DW,
  parameter bit COL_RD = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 we,
  input  logic [1:0]           row,
  input  logic [1:0]           col,
  input  logic [DW-1:0]        wdata,
  input  logic [1:0]           rd_idx,
  output logic [N-1:0][DW-1:0] rdata
);

  logic [DW-1:0] mem [N][N];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < N; r++)
        for (int c = 0; c < N; c++)
          mem[r][c] <= '0;
    end else if (we) begin
      mem[row][col] <= wdata;
    end
  end

  always_comb begin
    rdata = '0;
    for (int i = 0; i < N; i++) begin
      if (COL_RD)
        rdata[i] = mem[i][rd_idx];
      else
        rdata[i] = mem[rd_idx][i];
    end
  end

endmodule

// File: rtl/matmul_feeder.sv
// matmul_feeder: buffers W and X, then drives clear and three load
// beats so the downstream MAC array ends holding C = W*X.
module matmul_feeder
  import matmul_pkg::*;
#(
  parameter int DW = matmul_pkg::DW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          in_sel,
  input  logic [1:0]    in_row,
  input  logic [1:0]    in_col,
  input  logic [DW-1:0] in_data,
  output logic          err,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic [DW-1:0] data_w1,
  output logic [DW-1:0] data_w2,
  output logic [DW-1:0] data_w3,
  output logic [DW-1:0] data_x1,
  output logic [DW-1:0] data_x2,
  output logic [DW-1:0] data_x3,
  output logic          load,
  output logic          clear
);

  state_t state, state_n;
  logic [1:0] k, k_n;
  logic clear_n, load_n, done_n, busy_n;
  logic wr_acc, bad_idx, we_w, we_x;
  logic [N-1:0][DW-1:0] w_col, x_row;

  assign in_ready = !busy;
  assign bad_idx  = (in_row == 2'd3) || (in_col == 2'd3);
  assign wr_acc   = in_valid && in_ready;
  assign we_w     = wr_acc && !bad_idx && (in_sel == SEL_W);
  assign we_x     = wr_acc && !bad_idx && (in_sel == SEL_X);

  matmul_operand_bank #(.DW(DW), .COL_RD(1'b1)) u_w_bank (
    .clk    (clk),
    .rst    (rst),
    .we     (we_w),
    .row    (in_row),
    .col    (in_col),
    .wdata  (in_data),
    .rd_idx (k_n),
    .rdata  (w_col)
  );

  matmul_operand_bank #(.DW(DW), .COL_RD(1'b0)) u_x_bank (
    .clk    (clk),
    .rst    (rst),
    .we     (we_x),
    .row    (in_row),
    .col    (in_col),
    .wdata  (in_data),
    .rd_idx (k_n),
    .rdata  (x_row)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      k     <= 2'd0;
    end else begin
      state <= state_n;
      k     <= k_n;
    end
  end

  always_comb begin
    state_n = state;
    k_n     = k;
    unique case (state)
      IDLE: if (start) state_n = CLR;
      CLR: begin
        state_n = STREAM;
        k_n     = 2'd0;
      end
      STREAM: begin
        if (k == 2'd2) begin
          state_n = DONE;
          k_n     = 2'd0;
        end else begin
          k_n = k + 2'd1;
        end
      end
      DONE: state_n = start ? CLR : IDLE;
      default: state_n = IDLE;
    endcase
    clear_n = (state_n == CLR);
    load_n  = (state_n == STREAM);
    done_n  = (state_n == DONE);
    busy_n  = clear_n || load_n;
  end

  // Outputs are registered from the next-state decode so they line up
  // with the state they describe.
  always_ff @(posedge clk) begin
    if (rst) begin
      clear   <= 1'b0;
      load    <= 1'b0;
      done    <= 1'b0;
      busy    <= 1'b0;
      err     <= 1'b0;
      data_w1 <= '0;
      data_w2 <= '0;
      data_w3 <= '0;
      data_x1 <= '0;
      data_x2 <= '0;
      data_x3 <= '0;
    end else begin
      clear   <= clear_n;
      load    <= load_n;
      done    <= done_n;
      busy    <= busy_n;
      err     <= wr_acc && bad_idx;
      data_w1 <= load_n ? w_col[0] : '0;
      data_w2 <= load_n ? w_col[1] : '0;
      data_w3 <= load_n ? w_col[2] : '0;
      data_x1 <= load_n ? x_row[0] : '0;
      data_x2 <= load_n ? x_row[1] : '0;
      data_x3 <= load_n ? x_row[2] : '0;
    end
  end

endmodule

// File: doc/matmul_feeder.md
# matmul_feeder

Operand sequencer directly upstream of the 3x3 `matrix_multiplier` array. It buffers a 3x3 weight matrix W and a 3x3 input matrix X written element-by-element over a valid/ready port. On `start`, it drives `clear`, then three `load` beats of W columns and X rows so the nine MAC accumulators end holding C = W·X. It signals `done` when the accumulators are final.

## Interface
- `DW`, default 4: element width; must match the MAC operand width.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  element write request.
- `in_ready`  out  1  write port can accept; equals `!busy`.
- `in_sel`  in  1  0 = W bank, 1 = X bank.
- `in_row`, `in_col`  in  2 each  element index, legal range 0..2.
- `in_data`  in  DW  element value, unsigned.
- `err`  out  1  one-cycle pulse when an accepted write has an index of 3.
- `start`  in  1  begin a multiply.
- `busy`  out  1  sequence in progress.
- `done`  out  1  one-cycle pulse; MAC outputs are final in this cycle.
- `data_w1`, `data_w2`, `data_w3`  out  DW each  column k of W; `data_w{i}` = W[i-1][k].
- `data_x1`, `data_x2`, `data_x3`  out  DW each  row k of X; `data_x{j}` = X[k][j-1].
- `load`, `clear`  out  1 each  MAC controls; every MAC clears on `clear` and accumulates w·x on `load`; `clear` has priority.

## Operation
- States: IDLE, CLR, STREAM, DONE. A 2-bit beat counter `k` (0..2) is used in STREAM.
- Write handshake: a write completes on an edge where `in_valid && in_ready`. The addressed element is overwritten.
  - Index 3 in row or column: the write is accepted but the data is discarded, and `err` pulses in the next cycle.
  - Writes while busy are not accepted; the source must hold them.
- IDLE: `start` moves to CLR. The banks keep their contents between runs.
- CLR: `clear`=1 for one cycle, then STREAM with k=0.
- STREAM: `load`=1, and the data outputs present beat k. k increments each cycle. After k=2 the state moves to DONE.
- DONE: `done`=1 for one cycle.
  - `start` here is accepted and moves to CLR (back-to-back runs).
  - Otherwise the state moves to IDLE.
- `start` in CLR or STREAM is ignored and not queued.
- A write and `start` on the same edge in IDLE or DONE: the write lands first, so the run uses the new value.
- All data outputs are 0 outside STREAM.
- Width rule: worst case C[i][j] = 3·15·15 = 675, which fits the MAC's 10-bit accumulator. In general, ACC_W ≥ 2·DW+2.
- `rst`: both banks, all outputs and `k` go to 0; the state goes to IDLE. Reset mid-sequence aborts the run; no `done` is issued and the MACs are not touched beyond the current cycle.

## Timing
- Reset values: `in_ready`=1; `busy`, `done`, `err`, `load`, `clear`=0; data outputs 0.
- `start` sampled at edge T0 in IDLE gives this cycle-by-cycle sequence:

  | Cycle | `clear` | `load` | `busy` | Beat | `done` |
  |---|---|---|---|---|---|
  | T0+1 | 1 | 0 | 1 | – | 0 |
  | T0+2 | 0 | 1 | 1 | k=0 | 0 |
  | T0+3 | 0 | 1 | 1 | k=1 | 0 |
  | T0+4 | 0 | 1 | 1 | k=2 | 0 |
  | T0+5 | 0 | 0 | 0 | – | 1 |

- Latency: start to done is 5 cycles. The back-to-back period is 5 cycles.
- All outputs are registered; no combinational path runs from the inputs to `load`, `clear` or the data outputs. `in_ready` is derived from state only.

## Structure
- Package `matmul_pkg`:
  - `N`=3, `DW`=4, `ACC_W`=10.
  - State enum {IDLE, CLR, STREAM, DONE}.
  - `in_sel` encodings `SEL_W`=0 and `SEL_X`=1.
  - Shared with `matrix_multiplier` and its downstream consumer.
- One sub-module, `matmul_operand_bank`: a 3x3×DW register file with a single write port and one column read port (for W) or one row read port (for X), selected by a parameter. It is instantiated twice. The FSM stays in `matmul_feeder`.

## Test plan
- **Reset and idle outputs:** assert `rst` for 2 cycles mid-STREAM → next cycle `load`=`clear`=`busy`=0, `in_ready`=1, data outputs 0, no `done`.
- **Identity multiply:** write W=I and X={1..9} row-major, pulse `start` → `clear` at T+1, `load` at T+2..T+4, `done` at T+5; the attached array reads o11..o33 = 1..9.
- **Saturation bound:** all elements 15 → all nine accumulators 675 at `done`; beat outputs all 15 on each beat.
- **Busy interlock:** `start` and `in_valid` at T+2 → `in_ready`=0, bank unchanged, no second run; the held write completes at T+5.
- **Bad index:** write with `in_row`=3 → accepted, `err`=1 for exactly one cycle, both banks unchanged.
- **Back-to-back runs:** `start` held high through `done` → second `clear` at T+6, second `done` at T+10; a write landing at T+5 is reflected in the second result.
